axi_lite_arbiter_2to1: RTL and testbench

Two-master to one-slave AXI-lite arbiter that shares a single `AXI_lite_slave` between two `AXI_lite_master` instances. Write (AW/W/B) and read (AR/R) paths are arbitrated independently, each with a round-robin grant that is held from address acceptance until the response handshake completes. It sits between the masters' AXI-lite ports and the slave's ports, with no address decode and no buffering of payload.

---
 rtl/axi_lite_arbiter_2to1.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_arbiter_2to1.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI-lite arbiter. The write path (AW/W/B) and the
// read path (AR/R) each run their own round-robin grant. A grant is held from
// address acceptance until the response handshake, and no payload is buffered.
module axi_lite_arbiter_2to1 #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  // master 0
  input  logic               m0_awvalid,
  output logic               m0_awready,
  input  logic [ADDR_WD-1:0] m0_awaddr,
  input  logic               m0_wvalid,
  output logic               m0_wready,
  input  logic [DATA_WD-1:0] m0_wdata,
  output logic               m0_bvalid,
  output logic [1:0]         m0_brsp,
  input  logic               m0_bready,
  input  logic               m0_arvalid,
  output logic               m0_arready,
  input  logic [ADDR_WD-1:0] m0_araddr,
  output logic               m0_rvalid,
  output logic [DATA_WD-1:0] m0_rdata,
  output logic [1:0]         m0_rrsp,
  input  logic               m0_rready,
  // master 1
  input  logic               m1_awvalid,
  output logic               m1_awready,
  input  logic [ADDR_WD-1:0] m1_awaddr,
  input  logic               m1_wvalid,
  output logic               m1_wready,
  input  logic [DATA_WD-1:0] m1_wdata,
  output logic               m1_bvalid,
  output logic [1:0]         m1_brsp,
  input  logic               m1_bready,
  input  logic               m1_arvalid,
  output logic               m1_arready,
  input  logic [ADDR_WD-1:0] m1_araddr,
  output logic               m1_rvalid,
  output logic [DATA_WD-1:0] m1_rdata,
  output logic [1:0]         m1_rrsp,
  input  logic               m1_rready,
  // slave
  output logic               s_awvalid,
  input  logic               s_awready,
  output logic [ADDR_WD-1:0] s_awaddr,
  output logic               s_wvalid,
  input  logic               s_wready,
  output logic [DATA_WD-1:0] s_wdata,
  input  logic               s_bvalid,
  input  logic [1:0]         s_brsp,
  output logic               s_bready,
  output logic               s_arvalid,
  input  logic               s_arready,
  output logic [ADDR_WD-1:0] s_araddr,
  input  logic               s_rvalid,
  input  logic [DATA_WD-1:0] s_rdata,
  input  logic [1:0]         s_rrsp,
  output logic               s_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  logic     wgnt, wgnt_nxt;
  logic     wptr, wptr_nxt;
  logic     aw_done, aw_done_nxt;
  logic     w_done, w_done_nxt;
  logic     aw_hs, w_hs, aw_rdy, w_rdy;

  r_state_t r_state, r_state_nxt;
  logic     rgnt, rgnt_nxt;
  logic     rptr, rptr_nxt;

  logic     gnt_awvalid, gnt_wvalid, gnt_bready;
  logic     gnt_arvalid, gnt_rready;

  // The granted master's request-side signals; payloads go straight to the
  // slave because they are don't-care whenever the matching valid is low.
  assign gnt_awvalid = wgnt ? m1_awvalid : m0_awvalid;
  assign gnt_wvalid  = wgnt ? m1_wvalid  : m0_wvalid;
  assign gnt_bready  = wgnt ? m1_bready  : m0_bready;
  assign gnt_arvalid = rgnt ? m1_arvalid : m0_arvalid;
  assign gnt_rready  = rgnt ? m1_rready  : m0_rready;

  assign s_awaddr = wgnt ? m1_awaddr : m0_awaddr;
  assign s_wdata  = wgnt ? m1_wdata  : m0_wdata;
  assign s_araddr = rgnt ? m1_araddr : m0_araddr;

  // Response payloads are shared; only the valids pick the receiver.
  assign m0_brsp  = s_brsp;
  assign m1_brsp  = s_brsp;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rrsp  = s_rrsp;
  assign m1_rrsp  = s_rrsp;

  // Write path state, grant, priority pointer and per-channel done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wgnt    <= 1'b0;
      wptr    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      wgnt    <= wgnt_nxt;
      wptr    <= wptr_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  // Write path arbitration, AW/W routing with done masking, and B routing.
  always_comb begin
    w_state_nxt = w_state;
    wgnt_nxt    = wgnt;
    wptr_nxt    = wptr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    aw_rdy      = 1'b0;
    w_rdy       = 1'b0;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    m0_awready  = 1'b0;
    m1_awready  = 1'b0;
    m0_wready   = 1'b0;
    m1_wready   = 1'b0;
    m0_bvalid   = 1'b0;
    m1_bvalid   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (m0_awvalid || m1_awvalid) begin
          w_state_nxt = W_ADDR;
          if (m0_awvalid && m1_awvalid) wgnt_nxt = wptr;
          else                          wgnt_nxt = m1_awvalid;
        end
      end
      W_ADDR: begin
        s_awvalid  = gnt_awvalid & ~aw_done;
        s_wvalid   = gnt_wvalid & ~w_done;
        aw_rdy     = s_awready & ~aw_done;
        w_rdy      = s_wready & ~w_done;
        m0_awready = ~wgnt & aw_rdy;
        m1_awready = wgnt & aw_rdy;
        m0_wready  = ~wgnt & w_rdy;
        m1_wready  = wgnt & w_rdy;
        aw_hs      = s_awvalid & s_awready;
        w_hs       = s_wvalid & s_wready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_bready  = gnt_bready;
        m0_bvalid = ~wgnt & s_bvalid;
        m1_bvalid = wgnt & s_bvalid;
        if (s_bvalid && gnt_bready) begin
          w_state_nxt = W_IDLE;
          wptr_nxt    = ~wgnt;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read path state, grant and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rgnt    <= 1'b0;
      rptr    <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      rgnt    <= rgnt_nxt;
      rptr    <= rptr_nxt;
    end
  end

  // Read path arbitration, AR routing and R routing.
  always_comb begin
    r_state_nxt = r_state;
    rgnt_nxt    = rgnt;
    rptr_nxt    = rptr;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          r_state_nxt = R_ADDR;
          if (m0_arvalid && m1_arvalid) rgnt_nxt = rptr;
          else                          rgnt_nxt = m1_arvalid;
        end
      end
      R_ADDR: begin
        s_arvalid  = gnt_arvalid;
        m0_arready = ~rgnt & s_arready;
        m1_arready = rgnt & s_arready;
        if (gnt_arvalid && s_arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_rready  = gnt_rready;
        m0_rvalid = ~rgnt & s_rvalid;
        m1_rvalid = rgnt & s_rvalid;
        if (s_rvalid && gnt_rready) begin
          r_state_nxt = R_IDLE;
          rptr_nxt    = ~rgnt;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Self-checking bench for axi_lite_arbiter_2to1: two transaction-level master
// agents, a memory-backed slave and a path-ownership reference model.
module tb_axi_lite_arbiter_2to1;

  logic clk = 1'b0;
  logic rst_n;

  logic       awvalid [2], awready [2], wvalid [2], wready [2];
  logic       bvalid [2], bready [2], arvalid [2], arready [2];
  logic       rvalid [2], rready [2];
  logic [7:0] awaddr [2], araddr [2], wdata [2], rdata [2];
  logic [1:0] brsp [2], rrsp [2];

  logic       s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic       s_arvalid, s_arready, s_rvalid, s_rready;
  logic [7:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [1:0] s_brsp, s_rrsp;

  // master agent state
  bit         wact [2], aw_sent [2], w_sent [2], ract [2], ar_sent [2];
  logic [7:0] waddr [2], wdat [2], raddr [2];
  int         wdelay [2], wlat [2], rlat [2], last_wlat [2], last_rlat [2];
  int         bcount [2], rcount [2];

  // slave model state
  bit         sv_aw_have, sv_w_have, sv_b_pend, sv_ar_have;
  logic [7:0] sv_aw_q, sv_w_q, sv_ar_q;
  logic [7:0] smem [256];
  bit         slv_rand, slv_wstall, slv_bhold, mst_rand;

  // reference model: who owns each path, round-robin pointer, memory contents
  logic [7:0] ref_mem [256];
  bit         m_wbusy, m_rbusy;
  int         m_wown, m_rown, m_wptr, m_rptr;
  int         wlog [$];
  int         rlog [$];

  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter_2to1 #(.DATA_WD(8), .ADDR_WD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awvalid(awvalid[0]), .m0_awready(awready[0]), .m0_awaddr(awaddr[0]),
    .m0_wvalid(wvalid[0]), .m0_wready(wready[0]), .m0_wdata(wdata[0]),
    .m0_bvalid(bvalid[0]), .m0_brsp(brsp[0]), .m0_bready(bready[0]),
    .m0_arvalid(arvalid[0]), .m0_arready(arready[0]), .m0_araddr(araddr[0]),
    .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_rrsp(rrsp[0]), .m0_rready(rready[0]),
    .m1_awvalid(awvalid[1]), .m1_awready(awready[1]), .m1_awaddr(awaddr[1]),
    .m1_wvalid(wvalid[1]), .m1_wready(wready[1]), .m1_wdata(wdata[1]),
    .m1_bvalid(bvalid[1]), .m1_brsp(brsp[1]), .m1_bready(bready[1]),
    .m1_arvalid(arvalid[1]), .m1_arready(arready[1]), .m1_araddr(araddr[1]),
    .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_rrsp(rrsp[1]), .m1_rready(rready[1]),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_brsp(s_brsp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rrsp(s_rrsp), .s_rready(s_rready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] allCtl();
    return {awready[0], wready[0], bvalid[0], arready[0], rvalid[0],
            awready[1], wready[1], bvalid[1], arready[1], rvalid[1],
            s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};
  endfunction

  task automatic driveIdle();
    for (int i = 0; i < 2; i++) begin
      awvalid[i] = 1'b0; wvalid[i] = 1'b0; bready[i] = 1'b0;
      arvalid[i] = 1'b0; rready[i] = 1'b0;
      awaddr[i] = 8'h00; wdata[i] = 8'h00; araddr[i] = 8'h00;
    end
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_brsp = 2'b00;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 8'h00; s_rrsp = 2'b00;
  endtask

  task automatic clearState();
    for (int i = 0; i < 2; i++) begin
      wact[i] = 1'b0; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
      ract[i] = 1'b0; ar_sent[i] = 1'b0; wdelay[i] = 0;
    end
    sv_aw_have = 1'b0; sv_w_have = 1'b0; sv_b_pend = 1'b0; sv_ar_have = 1'b0;
    slv_wstall = 1'b0; slv_bhold = 1'b0;
    m_wbusy = 1'b0; m_rbusy = 1'b0; m_wptr = 0; m_rptr = 0;
  endtask

  task automatic issueWrite(input int i, input logic [7:0] a, input logic [7:0] d, input int dly);
    wact[i] = 1'b1; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
    waddr[i] = a; wdat[i] = d; wdelay[i] = dly; wlat[i] = 0;
  endtask

  task automatic issueRead(input int i, input logic [7:0] a);
    ract[i] = 1'b1; ar_sent[i] = 1'b0; raddr[i] = a; rlat[i] = 0;
  endtask

  // One clock cycle: drive at the negedge, check settled outputs, then book
  // every handshake that the coming posedge will complete.
  task automatic applyStimulus();
    logic [1:0] awh, wh, bh, arh, rh;
    logic       s_awh, s_wh, s_bh, s_arh, s_rh;
    int         o, n;
    @(negedge clk);
    s_awready = !sv_aw_have && (!slv_rand || $urandom_range(0, 1) == 1);
    s_wready  = !sv_w_have && !slv_wstall && (!slv_rand || $urandom_range(0, 1) == 1);
    s_bvalid  = sv_b_pend;
    s_brsp    = sv_aw_q[7:6];
    s_arready = !sv_ar_have && (!slv_rand || $urandom_range(0, 1) == 1);
    s_rvalid  = sv_ar_have;
    s_rdata   = smem[sv_ar_q];
    s_rrsp    = sv_ar_q[7:6];
    for (int i = 0; i < 2; i++) begin
      awvalid[i] = wact[i] && !aw_sent[i];
      awaddr[i]  = awvalid[i] ? waddr[i] : 8'($urandom);
      wvalid[i]  = wact[i] && !w_sent[i] && (wdelay[i] == 0);
      wdata[i]   = wvalid[i] ? wdat[i] : 8'($urandom);
      bready[i]  = !mst_rand || $urandom_range(0, 1) == 1;
      arvalid[i] = ract[i] && !ar_sent[i];
      araddr[i]  = arvalid[i] ? raddr[i] : 8'($urandom);
      rready[i]  = !mst_rand || $urandom_range(0, 1) == 1;
    end
    #1;
    // write path ownership and routing
    if (!m_wbusy) begin
      checkOutput("w_idle_quiet", 32'({awready[0], wready[0], bvalid[0], awready[1], wready[1],
                                       bvalid[1], s_awvalid, s_wvalid, s_bready}), 32'd0);
      if (awvalid[0] || awvalid[1]) begin
        m_wown  = (awvalid[0] && awvalid[1]) ? m_wptr : (awvalid[1] ? 1 : 0);
        m_wbusy = 1'b1;
        wlog.push_back(m_wown);
      end
    end else begin
      o = m_wown; n = 1 - o;
      checkOutput("w_other_quiet", 32'({awready[n], wready[n], bvalid[n]}), 32'd0);
      checkOutput("s_awvalid", 32'(s_awvalid), 32'(awvalid[o]));
      checkOutput("s_wvalid", 32'(s_wvalid), 32'(wvalid[o]));
      if (s_awvalid) checkOutput("s_awaddr", 32'(s_awaddr), 32'(waddr[o]));
      if (s_wvalid)  checkOutput("s_wdata", 32'(s_wdata), 32'(wdat[o]));
      if (awvalid[o]) checkOutput("m_awready", 32'(awready[o]), 32'(s_awready));
      if (wvalid[o])  checkOutput("m_wready", 32'(wready[o]), 32'(s_wready));
      checkOutput("m_bvalid", 32'(bvalid[o]), (aw_sent[o] && w_sent[o]) ? 32'(s_bvalid) : 32'd0);
      checkOutput("s_bready", 32'(s_bready), (aw_sent[o] && w_sent[o]) ? 32'(bready[o]) : 32'd0);
    end
    // read path ownership and routing
    if (!m_rbusy) begin
      checkOutput("r_idle_quiet", 32'({arready[0], rvalid[0], arready[1], rvalid[1],
                                       s_arvalid, s_rready}), 32'd0);
      if (arvalid[0] || arvalid[1]) begin
        m_rown  = (arvalid[0] && arvalid[1]) ? m_rptr : (arvalid[1] ? 1 : 0);
        m_rbusy = 1'b1;
        rlog.push_back(m_rown);
      end
    end else begin
      o = m_rown; n = 1 - o;
      checkOutput("r_other_quiet", 32'({arready[n], rvalid[n]}), 32'd0);
      checkOutput("s_arvalid", 32'(s_arvalid), 32'(arvalid[o]));
      if (s_arvalid) checkOutput("s_araddr", 32'(s_araddr), 32'(raddr[o]));
      if (arvalid[o]) checkOutput("m_arready", 32'(arready[o]), 32'(s_arready));
      checkOutput("m_rvalid", 32'(rvalid[o]), ar_sent[o] ? 32'(s_rvalid) : 32'd0);
      checkOutput("s_rready", 32'(s_rready), ar_sent[o] ? 32'(rready[o]) : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      awh[i] = awvalid[i] && awready[i];
      wh[i]  = wvalid[i] && wready[i];
      bh[i]  = bvalid[i] && bready[i];
      arh[i] = arvalid[i] && arready[i];
      rh[i]  = rvalid[i] && rready[i];
    end
    s_awh = s_awvalid && s_awready;
    s_wh  = s_wvalid && s_wready;
    s_bh  = s_bvalid && s_bready;
    s_arh = s_arvalid && s_arready;
    s_rh  = s_rvalid && s_rready;
    // slave memory model
    if (s_bh) begin sv_aw_have = 1'b0; sv_w_have = 1'b0; sv_b_pend = 1'b0; end
    if (s_awh) begin sv_aw_have = 1'b1; sv_aw_q = s_awaddr; end
    if (s_wh)  begin sv_w_have = 1'b1; sv_w_q = s_wdata; end
    if (sv_aw_have && sv_w_have && !sv_b_pend && !slv_bhold) begin
      smem[sv_aw_q] = sv_w_q;
      sv_b_pend = 1'b1;
    end
    if (s_rh)  sv_ar_have = 1'b0;
    if (s_arh) begin sv_ar_have = 1'b1; sv_ar_q = s_araddr; end
    // master agents and reference model completion
    for (int i = 0; i < 2; i++) begin
      if (awh[i]) aw_sent[i] = 1'b1;
      if (wh[i])  w_sent[i] = 1'b1;
      if (arh[i]) ar_sent[i] = 1'b1;
      if (bh[i]) begin
        checkOutput("b_owner", 32'(i), m_wbusy ? 32'(m_wown) : 32'hFFFF);
        checkOutput("brsp", 32'(brsp[i]), 32'(waddr[i][7:6]));
        ref_mem[waddr[i]] = wdat[i];
        last_wlat[i] = wlat[i];
        bcount[i]++;
        wact[i] = 1'b0;
        m_wbusy = 1'b0;
        m_wptr = 1 - i;
      end
      if (rh[i]) begin
        checkOutput("r_owner", 32'(i), m_rbusy ? 32'(m_rown) : 32'hFFFF);
        checkOutput("rdata", 32'(rdata[i]), 32'(ref_mem[raddr[i]]));
        checkOutput("rrsp", 32'(rrsp[i]), 32'(raddr[i][7:6]));
        last_rlat[i] = rlat[i];
        rcount[i]++;
        ract[i] = 1'b0;
        m_rbusy = 1'b0;
        m_rptr = 1 - i;
      end
      if (wact[i] && wdelay[i] > 0) wdelay[i]--;
      if (wact[i]) wlat[i]++;
      if (ract[i]) rlat[i]++;
    end
  endtask

  task automatic runUntilIdle(input int budget);
    int cnt = 0;
    while ((wact[0] || wact[1] || ract[0] || ract[1] || m_wbusy || m_rbusy) && cnt < budget) begin
      applyStimulus();
      cnt++;
    end
    checkOutput("drain", 32'(wact[0] || wact[1] || ract[0] || ract[1] || m_wbusy || m_rbusy), 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    driveIdle();
    clearState();
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_quiet", 32'(allCtl()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx, issued0, issued1, cyc;
    for (int a = 0; a < 256; a++) begin
      smem[a] = 8'(a) ^ 8'h5A;
      ref_mem[a] = 8'(a) ^ 8'h5A;
    end
    for (int i = 0; i < 2; i++) begin bcount[i] = 0; rcount[i] = 0; end
    slv_rand = 1'b0; mst_rand = 1'b0;
    doReset();

    // single write from m0, zero-wait slave
    issueWrite(0, 8'h12, 8'h34, 0);
    runUntilIdle(20);
    checkOutput("single_lat", 32'(last_wlat[0]), 32'd2);
    checkOutput("single_mem", 32'(smem[8'h12]), 32'h34);
    checkOutput("single_m1_quiet", 32'(bcount[1]), 32'd0);
    // pointer now favours m1
    idx = wlog.size();
    issueWrite(0, 8'h20, 8'h01, 0);
    issueWrite(1, 8'h21, 8'h02, 0);
    runUntilIdle(30);
    checkOutput("ptr_after_m0_first", 32'(wlog[idx]), 32'd1);
    checkOutput("ptr_after_m0_second", 32'(wlog[idx+1]), 32'd0);

    // simultaneous writes straight after reset
    doReset();
    idx = wlog.size();
    issueWrite(0, 8'h01, 8'hA1, 0);
    issueWrite(1, 8'h02, 8'hB2, 0);
    runUntilIdle(30);
    checkOutput("simul_first", 32'(wlog[idx]), 32'd0);
    checkOutput("simul_second", 32'(wlog[idx+1]), 32'd1);
    checkOutput("simul_m0_lat", 32'(last_wlat[0]), 32'd2);
    checkOutput("simul_m1_lat", 32'(last_wlat[1]), 32'd5);
    checkOutput("simul_mem0", 32'(smem[8'h01]), 32'hA1);
    checkOutput("simul_mem1", 32'(smem[8'h02]), 32'hB2);

    // continuous readers alternate
    idx = rlog.size();
    issued0 = 0; issued1 = 0; cyc = 0;
    while ((issued0 < 4 || issued1 < 4 || ract[0] || ract[1]) && cyc < 200) begin
      if (!ract[0] && issued0 < 4) begin issueRead(0, 8'h01); issued0++; end
      if (!ract[1] && issued1 < 4) begin issueRead(1, 8'h02); issued1++; end
      applyStimulus();
      cyc++;
    end
    runUntilIdle(20);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("rr_grant%0d", k), 32'(rlog[idx+k]), 32'(k % 2));

    // split AW and W with a stalled slave wready
    slv_wstall = 1'b1;
    idx = bcount[0];
    issueWrite(0, 8'h30, 8'h5C, 3);
    repeat (5) applyStimulus();
    slv_wstall = 1'b0;
    runUntilIdle(20);
    repeat (3) applyStimulus();
    checkOutput("split_lat", 32'(last_wlat[0]), 32'd6);
    checkOutput("split_one_b", 32'(bcount[0] - idx), 32'd1);
    checkOutput("split_mem", 32'(smem[8'h30]), 32'h5C);

    // concurrent write and read
    issueWrite(0, 8'h10, 8'hA5, 0);
    issueRead(1, 8'h90);
    runUntilIdle(20);
    checkOutput("conc_wlat", 32'(last_wlat[0]), 32'd2);
    checkOutput("conc_rlat", 32'(last_rlat[1]), 32'd2);

    // reset while the write path waits for B
    issueWrite(0, 8'h40, 8'h77, 0);
    runUntilIdle(20);
    slv_bhold = 1'b1;
    issueWrite(0, 8'h41, 8'h88, 0);
    repeat (3) applyStimulus();
    issueWrite(1, 8'h42, 8'h99, 0);
    applyStimulus();
    checkOutput("pre_reset_in_resp", 32'(s_bready), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_quiet", 32'(allCtl()), 32'd0);
    driveIdle();
    clearState();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idx = wlog.size();
    issueWrite(1, 8'h43, 8'h11, 0);
    issueWrite(0, 8'h44, 8'h22, 0);
    runUntilIdle(30);
    checkOutput("post_reset_first", 32'(wlog[idx]), 32'd0);

    // randomized traffic: writes below 0x80, reads above
    slv_rand = 1'b1; mst_rand = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!wact[i] && $urandom_range(0, 3) == 0)
          issueWrite(i, {1'b0, 7'($urandom)}, 8'($urandom), $urandom_range(0, 2));
        if (!ract[i] && $urandom_range(0, 3) == 0)
          issueRead(i, {1'b1, 7'($urandom)});
      end
      applyStimulus();
    end
    runUntilIdle(300);
    // read back from the written region
    for (int k = 0; k < 4; k++) begin
      issueRead(0, {1'b0, 7'($urandom)});
      issueRead(1, {1'b0, 7'($urandom)});
      runUntilIdle(100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
